// File: rtl/crossbar_mcast_sched_pkg.sv
// Shared types and the round-robin pointer increment used by the multicast crossbar scheduler.
package crossbar_pkg;

    localparam int MAX_PORTS = 16;
    localparam int IDX_W     = $clog2(MAX_PORTS);

    typedef logic [IDX_W-1:0]     port_idx_t;
    typedef logic [MAX_PORTS-1:0] port_mask_t;

    // Wrap by comparison so non-power-of-two port counts cycle correctly.
    function automatic port_idx_t rr_next(input port_idx_t idx, input int unsigned ports);
        if (32'(idx) + 32'd1 >= ports) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/crossbar_mcast_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr (mod N) wins.
module rr_arbiter
    import crossbar_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  port_idx_t    ptr,
    output logic [N-1:0] gnt,
    output logic         any,
    output port_idx_t    idx
);

    int cand;

    always_comb begin
        gnt  = '0;
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = port_idx_t'(cand);
            end
        end
    end

endmodule

// File: rtl/crossbar_mcast_sched.sv
// Multicast crossbar scheduler: per-output round-robin grants with partial-delivery tracking.
// Define CROSSBAR_MCAST_ATOMIC_EN for all-or-nothing multicast with a single global pointer.
module crossbar_mcast_sched
    import crossbar_pkg::*;
#(
    parameter int PORTS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] valid_i,
    input  logic [PORTS-1:0] mask_i [PORTS],
    input  logic [PORTS-1:0] out_ready_i,
    output logic [PORTS-1:0] dest_o [PORTS],
    output logic [PORTS-1:0] out_valid_o,
    output logic [PORTS-1:0] done_o
);

    logic [PORTS-1:0] served_reg [PORTS];
    logic [PORTS-1:0] served_next [PORTS];
    logic [PORTS-1:0] pend [PORTS];
    logic [PORTS-1:0] dest [PORTS];
    logic [PORTS-1:0] dest_col [PORTS];
    logic [PORTS-1:0] out_valid;
    logic [PORTS-1:0] done;

    genvar gi, gj;

    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_in
            assign pend[gi] = valid_i[gi] ? (mask_i[gi] & ~served_reg[gi]) : '0;
            assign done[gi] = valid_i[gi] & ((pend[gi] & ~dest[gi]) == '0);

            always_ff @(posedge clk) begin
                if (rst) begin
                    served_reg[gi] <= '0;
                end else begin
                    served_reg[gi] <= served_next[gi];
                end
            end

            for (gj = 0; gj < PORTS; gj++) begin : g_tr
                assign dest_col[gj][gi] = dest[gi][gj];
            end
        end

        for (gj = 0; gj < PORTS; gj++) begin : g_ov
            assign out_valid[gj] = |dest_col[gj];
        end
    endgenerate

`ifdef CROSSBAR_MCAST_ATOMIC_EN

    port_idx_t        gptr_reg;
    port_idx_t        gptr_next;
    port_idx_t        first_idx;
    logic             first_found;
    logic [PORTS-1:0] claimed;
    int               cand;

    // Scan inputs from gptr; an input wins only if its whole pending set is free and ready.
    always_comb begin
        claimed     = '0;
        first_found = 1'b0;
        first_idx   = '0;
        cand        = 0;
        for (int i = 0; i < PORTS; i++) begin
            dest[i] = '0;
        end
        for (int k = 0; k < PORTS; k++) begin
            cand = int'(gptr_reg) + k;
            if (cand >= PORTS) begin
                cand = cand - PORTS;
            end
            if ((pend[cand] != '0) && ((pend[cand] & ~out_ready_i) == '0) &&
                ((pend[cand] & claimed) == '0)) begin
                dest[cand] = pend[cand];
                claimed    = claimed | pend[cand];
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = port_idx_t'(cand);
                end
            end
        end
    end

    assign gptr_next = first_found ? rr_next(first_idx, PORTS) : gptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            gptr_reg <= '0;
        end else begin
            gptr_reg <= gptr_next;
        end
    end

    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_srv
            assign served_next[gi] = '0;
        end
    endgenerate

`else

    logic [PORTS-1:0] col_req [PORTS];
    logic [PORTS-1:0] col_gnt [PORTS];
    logic [PORTS-1:0] col_any;
    port_idx_t        col_idx [PORTS];
    port_idx_t        ptr_reg [PORTS];
    port_idx_t        ptr_next [PORTS];

    generate
        for (gj = 0; gj < PORTS; gj++) begin : g_out
            for (gi = 0; gi < PORTS; gi++) begin : g_req
                assign col_req[gj][gi] = pend[gi][gj] & out_ready_i[gj];
                assign dest[gi][gj]    = col_gnt[gj][gi];
            end

            rr_arbiter #(
                .N (PORTS)
            ) u_arb (
                .req (col_req[gj]),
                .ptr (ptr_reg[gj]),
                .gnt (col_gnt[gj]),
                .any (col_any[gj]),
                .idx (col_idx[gj])
            );

            assign ptr_next[gj] = col_any[gj] ? rr_next(col_idx[gj], PORTS) : ptr_reg[gj];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr_reg[gj] <= '0;
                end else begin
                    ptr_reg[gj] <= ptr_next[gj];
                end
            end
        end

        // A finished message clears its record so a replacement starts from scratch.
        for (gi = 0; gi < PORTS; gi++) begin : g_srv
            assign served_next[gi] = done[gi] ? '0 : (served_reg[gi] | dest[gi]);
        end
    endgenerate

`endif

    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_dout
            assign dest_o[gi] = rst ? '0 : dest[gi];
        end
    endgenerate

    assign out_valid_o = rst ? '0 : out_valid;
    assign done_o      = rst ? '0 : done;

endmodule

// File: tb/tb_crossbar_mcast_sched.sv
// Directed bench for crossbar_mcast_sched (PORTS=4, default per-output scheduling build).
module tb_crossbar_mcast_sched;

    logic       clk;
    logic       rst;
    logic [3:0] valid_i;
    logic [3:0] mask_i [4];
    logic [3:0] out_ready_i;
    logic [3:0] dest_o [4];
    logic [3:0] out_valid_o;
    logic [3:0] done_o;

    int n_checks;
    int n_errors;

    crossbar_mcast_sched #(
        .PORTS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .mask_i      (mask_i),
        .out_ready_i (out_ready_i),
        .dest_o      (dest_o),
        .out_valid_o (out_valid_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end else begin
            $display("ok   %s = %b", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_i = '0;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        valid_i     = 4'b0001;
        out_ready_i = 4'b1111;
        for (int i = 0; i < 4; i++) mask_i[i] = 4'b0000;
        mask_i[0] = 4'b0110;
        #2;
        check("rst_dest0", dest_o[0], 4'b0000);
        check("rst_done", done_o, 4'b0000);
        check("rst_outv", out_valid_o, 4'b0000);
        tick();
        tick();
        rst = 1'b0;

        // single multicast delivered in one cycle, record cleared after done
        #1;
        check("mc_dest0", dest_o[0], 4'b0110);
        check("mc_done", done_o, 4'b0001);
        check("mc_outv", out_valid_o, 4'b0110);
        tick();
        check("mc_again_dest0", dest_o[0], 4'b0110);
        check("mc_again_done", done_o, 4'b0001);

        // zero mask: dropped immediately, nothing granted
        mask_i[0] = 4'b0000;
        #1;
        check("zero_done", done_o, 4'b0001);
        check("zero_outv", out_valid_o, 4'b0000);

        // contention on output 0
        do_reset();
        valid_i   = 4'b0011;
        mask_i[0] = 4'b0011;
        mask_i[1] = 4'b0001;
        #1;
        check("cont_c0_dest0", dest_o[0], 4'b0011);
        check("cont_c0_dest1", dest_o[1], 4'b0000);
        check("cont_c0_done", done_o, 4'b0001);
        tick();
        valid_i[0] = 1'b0;
        #1;
        check("cont_c1_dest1", dest_o[1], 4'b0001);
        check("cont_c1_done", done_o, 4'b0010);

        // partial delivery across stalled output
        do_reset();
        valid_i     = 4'b0100;
        mask_i[2]   = 4'b1010;
        out_ready_i = 4'b0010;
        #1;
        check("part_c0_dest2", dest_o[2], 4'b0010);
        check("part_c0_done", done_o, 4'b0000);
        tick();
        check("part_c1_dest2", dest_o[2], 4'b0000);
        check("part_c1_done", done_o, 4'b0000);
        tick();
        check("part_c2_dest2", dest_o[2], 4'b0000);
        tick();
        out_ready_i = 4'b1111;
        #1;
        check("part_c3_dest2", dest_o[2], 4'b1000);
        check("part_c3_done", done_o, 4'b0100);
        check("part_c3_outv", out_valid_o, 4'b1000);

        // fairness on output 0 with all inputs re-presenting
        do_reset();
        for (int i = 0; i < 4; i++) mask_i[i] = 4'b0001;
        valid_i = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            logic [3:0] exp_oh;
            exp_oh = 4'b0001 << (c % 4);
            #1;
            check($sformatf("rr_c%0d_done", c), done_o, exp_oh);
            check($sformatf("rr_c%0d_dest", c), dest_o[c % 4], 4'b0001);
            tick();
        end

        // reset mid-message loses the partial record
        do_reset();
        valid_i     = 4'b0001;
        mask_i[0]   = 4'b0111;
        out_ready_i = 4'b0001;
        #1;
        check("mrst_pre_dest0", dest_o[0], 4'b0001);
        check("mrst_pre_done", done_o, 4'b0000);
        tick();
        rst = 1'b1;
        #1;
        check("mrst_in_dest0", dest_o[0], 4'b0000);
        check("mrst_in_outv", out_valid_o, 4'b0000);
        tick();
        rst         = 1'b0;
        out_ready_i = 4'b1111;
        #1;
        check("mrst_post_dest0", dest_o[0], 4'b0111);
        check("mrst_post_done", done_o, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
